fifo_burst_reader: RTL and testbench

//   Read-side controller for the synchronous FIFO. On a start pulse it pops burst_len words

---
 rtl/fifo_burst_reader.sv | 113 +++++++++++
 tb/tb_fifo_burst_reader.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_burst_reader.sv
// Read-side burst controller: pops burst_len words from a registered-output FIFO
// and re-times them through a 3-entry queue onto a valid/ready stream.
module fifo_burst_reader #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  burst_len,
  output logic                  busy,
  output logic                  done,
  output logic [LEN_WIDTH-1:0]  words_left,
  input  logic                  fifo_empty,
  output logic                  fifo_rd,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last
);

  localparam int unsigned QDEPTH = 3;
  localparam int unsigned OCC_W  = 2;
  localparam int unsigned CMP_W  = 3;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [LEN_WIDTH-1:0]   issue_cnt_q, issue_cnt_d;
  logic [LEN_WIDTH-1:0]   words_left_q, words_left_d;
  logic [OCC_W-1:0]       occ_q, occ_d;
  logic                   inflight_q;
  logic [DATA_WIDTH-1:0]  q_mem [QDEPTH];
  logic                   busy_q, done_q, m_valid_q, m_last_q;

  logic                   rd_c, pop_c, push_c;
  logic [OCC_W-1:0]       wr_idx_c;

  // Pop only when queue slots cover every word already requested; no m_ready path.
  always_comb begin
    rd_c     = (state_q == S_READ) && !fifo_empty && (issue_cnt_q != '0) &&
               ((CMP_W'(occ_q) + CMP_W'(inflight_q)) < CMP_W'(QDEPTH));
    pop_c    = (occ_q != '0) && m_ready;
    push_c   = inflight_q;
    wr_idx_c = pop_c ? (occ_q - OCC_W'(1)) : occ_q;
  end

  // Next-state and counter updates.
  always_comb begin
    state_d      = state_q;
    issue_cnt_d  = issue_cnt_q;
    words_left_d = words_left_q;
    occ_d        = occ_q + OCC_W'(push_c) - OCC_W'(pop_c);

    if (rd_c) issue_cnt_d = issue_cnt_q - LEN_WIDTH'(1);
    if (pop_c && (words_left_q != '0)) words_left_d = words_left_q - LEN_WIDTH'(1);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          issue_cnt_d  = burst_len;
          words_left_d = burst_len;
          state_d      = (burst_len != '0) ? S_READ : S_DONE;
        end
      end
      S_READ:  if (issue_cnt_d == '0) state_d = S_DRAIN;
      S_DRAIN: if (words_left_d == '0) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      issue_cnt_q  <= '0;
      words_left_q <= '0;
      occ_q        <= '0;
      inflight_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      m_valid_q    <= 1'b0;
      m_last_q     <= 1'b0;
      for (int unsigned i = 0; i < QDEPTH; i++) q_mem[i] <= '0;
    end else begin
      state_q      <= state_d;
      issue_cnt_q  <= issue_cnt_d;
      words_left_q <= words_left_d;
      occ_q        <= occ_d;
      inflight_q   <= rd_c;
      busy_q       <= (state_d != S_IDLE);
      done_q       <= (state_d == S_DONE);
      m_valid_q    <= (occ_d != '0);
      m_last_q     <= (occ_d != '0) && (words_left_d == LEN_WIDTH'(1));
      // Head-at-index-0 shift queue; a push after the shift lands on the new tail.
      if (pop_c) begin
        q_mem[0] <= q_mem[1];
        q_mem[1] <= q_mem[2];
      end
      if (push_c) q_mem[wr_idx_c] <= fifo_data;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign words_left = words_left_q;
  assign fifo_rd    = rd_c;
  assign m_valid    = m_valid_q;
  assign m_data     = q_mem[0];
  assign m_last     = m_last_q;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: FIFO model, directed bursts, scoreboard monitor.
module tb_fifo_burst_reader;

  localparam int unsigned DW = 8;
  localparam int unsigned LW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [LW-1:0] burst_len = '0;
  logic          busy, done, fifo_empty, fifo_rd, m_valid, m_last;
  logic [LW-1:0] words_left;
  logic [DW-1:0] fifo_data = '0;
  logic [DW-1:0] m_data;
  logic          m_ready = 1'b1;

  fifo_burst_reader #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst), .start(start), .burst_len(burst_len),
    .busy(busy), .done(done), .words_left(words_left),
    .fifo_empty(fifo_empty), .fifo_rd(fifo_rd), .fifo_data(fifo_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
  );

  always #5 clk = ~clk;

  // FIFO model with one-cycle registered read data
  logic [DW-1:0] fmem [64];
  int unsigned   fw = 0;
  int unsigned   fr = 0;
  logic          underflow = 1'b0;
  assign fifo_empty = (fw == fr);

  always @(posedge clk) begin
    if (fifo_rd) begin
      if (fw == fr) underflow <= 1'b1;
      else begin
        fifo_data <= fmem[fr[5:0]];
        fr <= fr + 1;
      end
    end
  end

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_fifo(input logic [DW-1:0] d);
    fmem[fw[5:0]] = d;
    fw = fw + 1;
  endtask

  task automatic expect_burst(input logic [DW-1:0] base, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.data = base + DW'(i);
      e.last = (i == n - 1);
      exp_q.push_back(e);
    end
  endtask

  // Returns one step after the edge that samples start
  task automatic start_burst(input int len);
    @(posedge clk); #1;
    start = 1'b1;
    burst_len = LW'(len);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int max_cyc);
    bit seen = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk({name, "_done"}, 32'(seen), 32'd1);
    @(negedge clk);
    chk({name, "_pulse"}, 32'(done), 32'd0);
    chk({name, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit [5:0] pat;
    bit       seen;

    fork
      begin : monitor
        int   issued = 0;
        int   accepted = 0;
        bit   prev_stall = 1'b0;
        logic [DW-1:0] prev_data = '0;
        logic prev_last = 1'b0;
        exp_t e;
        forever begin
          @(negedge clk);
          if (rst) begin
            issued = 0;
            accepted = 0;
            prev_stall = 1'b0;
          end else begin
            if (prev_stall) begin
              chk("hold_valid", 32'(m_valid), 32'd1);
              chk("hold_data", 32'(m_data), 32'(prev_data));
              chk("hold_last", 32'(m_last), 32'(prev_last));
            end
            if (fifo_rd) begin
              chk("rd_window", 32'((issued - accepted) < 3), 32'd1);
              issued++;
            end
            if (m_valid && m_ready) begin
              if (exp_q.size() == 0) chk("sb_unexpected", 32'(m_data), 32'hFFFF_FFFF);
              else begin
                e = exp_q.pop_front();
                chk("sb_data", 32'(m_data), 32'(e.data));
                chk("sb_last", 32'(m_last), 32'(e.last));
              end
              accepted++;
            end
            prev_stall = m_valid && !m_ready;
            prev_data = m_data;
            prev_last = m_last;
          end
        end
      end
    join_none

    // Reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_fifo_rd", 32'(fifo_rd), 32'd0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_last", 32'(m_last), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_words_left", 32'(words_left), 32'd0);

    // Four-word burst at full rate: reads in cycles 1-4, last accepted at edge 6
    for (int i = 0; i < 4; i++) push_fifo(8'hA0 + DW'(i));
    expect_burst(8'hA0, 4);
    start_burst(4);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      chk("t2_rd", 32'(fifo_rd), 32'(c <= 4));
      chk("t2_done", 32'(done), 32'(c == 7));
      chk("t2_busy", 32'(busy), 32'(c <= 7));
    end

    // Six-word burst under back-pressure
    for (int i = 0; i < 6; i++) push_fifo(8'hD0 + DW'(i));
    expect_burst(8'hD0, 6);
    pat = 6'b101001;
    start_burst(6);
    seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      m_ready = pat[i % 6];
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("t3_done", 32'(seen), 32'd1);
    m_ready = 1'b1;
    @(negedge clk);
    chk("t3_pulse", 32'(done), 32'd0);
    chk("t3_idle", 32'(busy), 32'd0);

    // FIFO runs dry mid-burst, then refills
    push_fifo(8'hC0);
    push_fifo(8'hC1);
    expect_burst(8'hC0, 5);
    start_burst(5);
    chk("t4_wl_load", 32'(words_left), 32'd5);
    repeat (10) @(posedge clk);
    #1;
    chk("t4_stall_rd", 32'(fifo_rd), 32'd0);
    chk("t4_stall_busy", 32'(busy), 32'd1);
    chk("t4_stall_wl", 32'(words_left), 32'd3);
    chk("t4_stall_valid", 32'(m_valid), 32'd0);
    for (int i = 2; i < 5; i++) push_fifo(8'hC0 + DW'(i));
    wait_done("t4", 40);
    chk("t4_wl_end", 32'(words_left), 32'd0);

    // Zero-length burst; start held into DONE is ignored
    for (int i = 0; i < 10; i++) push_fifo(8'hB0 + DW'(i));
    @(posedge clk); #1;
    start = 1'b1;
    burst_len = '0;
    @(posedge clk); #1;
    chk("t5_done", 32'(done), 32'd1);
    chk("t5_busy", 32'(busy), 32'd1);
    chk("t5_rd", 32'(fifo_rd), 32'd0);
    burst_len = 8'd3;
    @(posedge clk); #1;
    start = 1'b0;
    chk("t5_pulse", 32'(done), 32'd0);
    chk("t5_ignored", 32'(busy), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_quiet_rd", 32'(fifo_rd), 32'd0);
      chk("t5_quiet_busy", 32'(busy), 32'd0);
    end

    // Reset mid-burst with a read outstanding (B0..B2 are consumed)
    m_ready = 1'b0;
    start_burst(8);
    @(posedge clk);
    @(posedge clk); #1;
    chk("t6_rd_issued", 32'(fifo_rd), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t6_valid", 32'(m_valid), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_wl", 32'(words_left), 32'd0);
    chk("t6_rd", 32'(fifo_rd), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_no_late", 32'(m_valid), 32'd0);
    end
    m_ready = 1'b1;
    expect_burst(8'hB3, 2);
    start_burst(2);
    wait_done("t6", 20);

    chk("fifo_left", 32'(fw - fr), 32'd5);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    chk("fifo_underflow", 32'(underflow), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
